linear_resampler: RTL
=====================

# linear_resampler

Parametrised linear-interpolation resampler for the voice-change path. It reads a frame of signed PCM samples from a dual-read source buffer and computes, for each output index n, the sample at fractional position n·ratio. Results stream out on a valid-qualified write port toward the output frame RAM. It supersedes the fixed 16-bit/Q7 interpolator with:

- parametrised width and depth,
- true signed arithmetic with rounding and saturation,
- a nearest-neighbour mode,
- explicit start/busy/done/abort control.

## Interface

Parameters:
- DATA_WIDTH, 16: signed sample width.
- FRAC_BITS, 7: fractional bits of ratio and position; FRAC_BITS ≥ 1.
- ADDR_WIDTH, 10: sample index width, for both source and output.
- RATIO_WIDTH, 10: ratio width in unsigned Q(RATIO_WIDTH−FRAC_BITS).FRAC_BITS format.

Ports:
- clk, input, 1: single clock for all logic.
- rst_n, input, 1: reset, synchronous and active-low.
- start, input, 1: one-cycle request; sampled only in IDLE.
- abort, input, 1: cancels the current run.
- mode, input, 1: 0 = linear, 1 = nearest-neighbour; latched at start.
- ratio, input, RATIO_WIDTH: position step per output sample; latched at start.
- in_len, input, ADDR_WIDTH: index of the last valid source sample; latched at start.
- out_len, input, ADDR_WIDTH: index of the last output sample; latched at start.
- src_addr_a, output, ADDR_WIDTH: source index idx (registered).
- src_addr_b, output, ADDR_WIDTH: source index min(idx+1, in_len) (registered).
- src_data_a, input, DATA_WIDTH: x[src_addr_a]; valid one cycle after the address (synchronous RAM).
- src_data_b, input, DATA_WIDTH: x[src_addr_b]; same read latency as src_data_a.
- out_valid, output, 1: out_data/out_addr are valid this cycle.
- out_addr, output, ADDR_WIDTH: output index n.
- out_data, output, DATA_WIDTH: signed interpolated sample.
- out_last, output, 1: high together with out_valid for n = out_len.
- busy, output, 1: run in progress.
- done, output, 1: one-cycle pulse after the last sample is emitted.

## Operation

- State machine: IDLE → RUN → DRAIN → DONE → IDLE.
  - IDLE: start=1 latches mode, ratio, in_len and out_len, clears n and pos, and enters RUN.
  - RUN: issues one address pair per cycle for n = 0..out_len. After issuing out_len it enters DRAIN.
  - DRAIN: waits 3 cycles for the pipeline to empty, then enters DONE.
  - DONE: asserts done for 1 cycle, then returns to IDLE.
- start outside IDLE is ignored.
- Position accumulator pos has width ADDR_WIDTH+FRAC_BITS+1, starts at 0 and adds ratio each cycle; no multiplier is used. It saturates at its maximum, never wraps.
- idx = pos >> FRAC_BITS; f = pos[FRAC_BITS−1:0].
- If idx ≥ in_len: both addresses = in_len and f is forced to 0, so the output holds the last sample.
- Linear mode (mode=0): y = (a·(2^FRAC_BITS − f) + b·f + 2^(FRAC_BITS−1)) >>> FRAC_BITS.
  - a and b are signed; products and sum are held at signed width DATA_WIDTH+FRAC_BITS+2.
  - Rounding is round-half-up (toward +∞) via the added constant and arithmetic shift.
- Nearest mode (mode=1): y = b if f ≥ 2^(FRAC_BITS−1), else a.
- The result saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. Saturation is defensive and must still be present.
- ratio = 0: every output is x[0].
- in_len = 0: every output is x[0].
- abort=1 in RUN/DRAIN/DONE:
  - Next cycle: state IDLE, busy=0, and out_valid is suppressed from that cycle on (in-flight samples discarded).
  - No done pulse is issued.
  - abort in IDLE has no effect.
- If start and abort are high in the same IDLE cycle, start wins.

## Timing

- Cycle k means the interval after rising edge k; start is sampled at edge 0.
- Address pair for sample n is visible in cycle 1+n. Source data is visible in cycle 2+n, products register at edge 3+n, and out_valid/out_addr=n/out_data appear in cycle 4+n.
- Throughput is 1 sample per cycle: out_valid is high for out_len+1 contiguous cycles, 4 through 4+out_len.
- out_last is high in cycle 4+out_len.
- busy is high in cycles 1 through 4+out_len.
- done is high in cycle 5+out_len only. The next start is accepted at edge 6+out_len.
- Reset (rst_n=0 at any edge, including mid-run): state IDLE and internal pipeline cleared. All outputs become 0: out_valid, out_last, busy, done, out_data, out_addr, src_addr_a and src_addr_b.

## Test plan

- Identity: FRAC_BITS=7, ratio=128, in_len=out_len=7, x[n]=100n → out_data 0,100,…,700 in cycles 4–11; out_last in cycle 11; done in cycle 12.
- Half-rate upsample: ratio=64, x[0]=0, x[1]=1000, x[2]=2000 → outputs 0,500,1000,1500,2000.
- Signed rounding: ratio=32, x[0]=−1000, x[1]=1000 → −1000,−500,0,500,1000. Also x[0]=−3, x[1]=−2, ratio=64 → output n=1 is −2 (round-half-up).
- End clamp: in_len=3, ratio=128, out_len=7, x={10,20,30,40} → 10,20,30,40,40,40,40,40; src_addr_b never exceeds 3.
- Nearest mode: mode=1, ratio=96, x={0,100,200,300} → 0,100,200,200.
- Control: start while busy is ignored. abort in cycle 6 of an out_len=15 run gives no out_valid from cycle 7 and no done; a new start is accepted after that. rst_n=0 mid-run clears all outputs at the next edge.

Source files
------------

// File: rtl/linear_resampler_if.sv
// Source-read and output-write bus of the linear resampler.
// The master side is the resampler; the slave side is the source RAM plus the output frame sink.
interface linear_resampler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] src_addr_a;
  logic [ADDR_WIDTH-1:0] src_addr_b;
  logic [DATA_WIDTH-1:0] src_data_a;
  logic [DATA_WIDTH-1:0] src_data_b;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output src_addr_a, src_addr_b,
    input  src_data_a, src_data_b,
    output out_valid, out_addr, out_data, out_last
  );

  modport slave (
    input  src_addr_a, src_addr_b,
    output src_data_a, src_data_b,
    input  out_valid, out_addr, out_data, out_last
  );
endinterface

// File: rtl/linear_resampler.sv
// Linear / nearest-neighbour resampler: address issue, RAM read, weighted sum, saturate.
// One sample per cycle; 4-cycle latency from issue state to out_valid.
module linear_resampler #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 7,
  parameter int ADDR_WIDTH  = 10,
  parameter int RATIO_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode,
  input  logic [RATIO_WIDTH-1:0] ratio,
  input  logic [ADDR_WIDTH-1:0]  in_len,
  input  logic [ADDR_WIDTH-1:0]  out_len,
  output logic                   busy,
  output logic                   done,
  linear_resampler_if.master     bus
);
  localparam int POS_W = ADDR_WIDTH + FRAC_BITS + 1;
  localparam int ACC_W = DATA_WIDTH + FRAC_BITS + 2;
  localparam logic signed [ACC_W-1:0] HALF_C = ACC_W'(1'b1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] MAX_V  = (ACC_W'(1'b1) << (DATA_WIDTH - 1)) - ACC_W'(1'b1);
  localparam logic signed [ACC_W-1:0] MIN_V  = ~MAX_V;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [RATIO_WIDTH-1:0]  ratio_q, ratio_d;
  logic [ADDR_WIDTH-1:0]   in_len_q, in_len_d, out_len_q, out_len_d;
  logic [ADDR_WIDTH-1:0]   n_q, n_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [1:0]              drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]   src_addr_a_q, src_addr_a_d, src_addr_b_q, src_addr_b_d;
  logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [ADDR_WIDTH-1:0]   s1_n_q, s1_n_d;
  logic [FRAC_BITS-1:0]    s1_f_q, s1_f_d;
  logic                    s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [ADDR_WIDTH-1:0]   s2_n_q, s2_n_d;
  logic [FRAC_BITS-1:0]    s2_f_q, s2_f_d;
  logic                    s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic [ADDR_WIDTH-1:0]   s3_n_q, s3_n_d;
  logic signed [ACC_W-1:0] s3_y_q, s3_y_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    busy_q, busy_d, done_q, done_d;

  logic                    flush;
  logic [ADDR_WIDTH:0]     idx;
  logic                    clamp;
  logic [POS_W:0]          pos_sum;
  logic [POS_W-1:0]        pos_next;
  logic signed [ACC_W-1:0] a_ext, b_ext, w_a, w_b, acc;

  function automatic logic [DATA_WIDTH-1:0] sat_data(input logic signed [ACC_W-1:0] v);
    if (v > MAX_V) begin
      return MAX_V[DATA_WIDTH-1:0];
    end else if (v < MIN_V) begin
      return MIN_V[DATA_WIDTH-1:0];
    end else begin
      return v[DATA_WIDTH-1:0];
    end
  endfunction

  assign flush    = abort && (state_q != S_IDLE);
  assign idx      = pos_q[POS_W-1:FRAC_BITS];
  assign clamp    = idx >= {1'b0, in_len_q};
  assign pos_sum  = {1'b0, pos_q} + (POS_W+1)'(ratio_q);
  // The accumulator sticks at all-ones instead of wrapping back to index 0.
  assign pos_next = pos_sum[POS_W] ? {POS_W{1'b1}} : pos_sum[POS_W-1:0];

  // Control FSM: run setup, address issue, drain timing and done pulse.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    ratio_d      = ratio_q;
    in_len_d     = in_len_q;
    out_len_d    = out_len_q;
    n_d          = n_q;
    pos_d        = pos_q;
    drain_d      = drain_q;
    src_addr_a_d = src_addr_a_q;
    src_addr_b_d = src_addr_b_q;
    s1_valid_d   = 1'b0;
    s1_last_d    = s1_last_q;
    s1_n_d       = s1_n_q;
    s1_f_d       = s1_f_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_RUN;
            mode_d    = mode;
            ratio_d   = ratio;
            in_len_d  = in_len;
            out_len_d = out_len;
            n_d       = {ADDR_WIDTH{1'b0}};
            pos_d     = {POS_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          busy_d       = 1'b1;
          s1_valid_d   = 1'b1;
          s1_n_d       = n_q;
          s1_last_d    = (n_q == out_len_q);
          src_addr_a_d = clamp ? in_len_q : idx[ADDR_WIDTH-1:0];
          src_addr_b_d = clamp ? in_len_q : idx[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1'b1);
          s1_f_d       = clamp ? {FRAC_BITS{1'b0}} : pos_q[FRAC_BITS-1:0];
          if (n_q == out_len_q) begin
            state_d = S_DRAIN;
            drain_d = 2'd0;
          end else begin
            n_d   = n_q + ADDR_WIDTH'(1'b1);
            pos_d = pos_next;
          end
        end
        S_DRAIN: begin
          busy_d = 1'b1;
          if (drain_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: RAM-aligned stage, weighted sum / nearest pick, saturated output.
  always_comb begin
    s2_valid_d  = s1_valid_q && !flush;
    s2_last_d   = s1_last_q;
    s2_n_d      = s1_n_q;
    s2_f_d      = s1_f_q;
    a_ext       = ACC_W'($signed(bus.src_data_a));
    b_ext       = ACC_W'($signed(bus.src_data_b));
    w_b         = ACC_W'(s2_f_q);
    w_a         = (ACC_W'(1'b1) << FRAC_BITS) - w_b;
    acc         = a_ext * w_a + b_ext * w_b + HALF_C;
    s3_valid_d  = s2_valid_q && !flush;
    s3_last_d   = s2_last_q;
    s3_n_d      = s2_n_q;
    if (mode_q) begin
      s3_y_d = s2_f_q[FRAC_BITS-1] ? b_ext : a_ext;
    end else begin
      s3_y_d = acc >>> FRAC_BITS;
    end
    out_valid_d = s3_valid_q && !flush;
    out_last_d  = s3_valid_q && s3_last_q && !flush;
    out_addr_d  = s3_valid_q ? s3_n_q : out_addr_q;
    out_data_d  = s3_valid_q ? sat_data(s3_y_q) : out_data_q;
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      ratio_q      <= {RATIO_WIDTH{1'b0}};
      in_len_q     <= {ADDR_WIDTH{1'b0}};
      out_len_q    <= {ADDR_WIDTH{1'b0}};
      n_q          <= {ADDR_WIDTH{1'b0}};
      pos_q        <= {POS_W{1'b0}};
      drain_q      <= 2'd0;
      src_addr_a_q <= {ADDR_WIDTH{1'b0}};
      src_addr_b_q <= {ADDR_WIDTH{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_n_q       <= {ADDR_WIDTH{1'b0}};
      s1_f_q       <= {FRAC_BITS{1'b0}};
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_n_q       <= {ADDR_WIDTH{1'b0}};
      s2_f_q       <= {FRAC_BITS{1'b0}};
      s3_valid_q   <= 1'b0;
      s3_last_q    <= 1'b0;
      s3_n_q       <= {ADDR_WIDTH{1'b0}};
      s3_y_q       <= {ACC_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_addr_q   <= {ADDR_WIDTH{1'b0}};
      out_data_q   <= {DATA_WIDTH{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ratio_q      <= ratio_d;
      in_len_q     <= in_len_d;
      out_len_q    <= out_len_d;
      n_q          <= n_d;
      pos_q        <= pos_d;
      drain_q      <= drain_d;
      src_addr_a_q <= src_addr_a_d;
      src_addr_b_q <= src_addr_b_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_n_q       <= s1_n_d;
      s1_f_q       <= s1_f_d;
      s2_valid_q   <= s2_valid_d;
      s2_last_q    <= s2_last_d;
      s2_n_q       <= s2_n_d;
      s2_f_q       <= s2_f_d;
      s3_valid_q   <= s3_valid_d;
      s3_last_q    <= s3_last_d;
      s3_n_q       <= s3_n_d;
      s3_y_q       <= s3_y_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.src_addr_a = src_addr_a_q;
  assign bus.src_addr_b = src_addr_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_data   = out_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule
